// File: rtl/trng_word_packer.sv
// trng_word_packer
//   Packs the serial output of the TRNG debiaser into WORD_W-bit words
//   (first accepted bit lands in bit 0) and buffers them in a first-word-
//   fall-through FIFO with a valid/ready read port. A repetition-count
//   health test watches the accepted bit stream; when it trips, packing
//   halts until software pulses clear_err. The FIFO keeps draining.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears all state
//   in_valid    in_bit is valid this cycle
//   in_bit      debiased random bit
//   clear_err   one-cycle pulse: clear overflow/rep_fail and resume packing
//   word_valid  FIFO non-empty
//   word_ready  consumer accepts the head word
//   word_data   FIFO head word; holds its last value while the FIFO is empty
//   fifo_count  number of words currently stored
//   overflow    sticky: a completed word was dropped because the FIFO was full
//   rep_fail    sticky: repetition-count test failed
module trng_word_packer #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        in_bit,
  input  logic                        clear_err,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [WORD_W-1:0]           word_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        rep_fail
);

  localparam int CNT_W  = $clog2(WORD_W);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int RUN_W  = $clog2(REP_LIMIT + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORD_W - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(REP_LIMIT);
  localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_PACK = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state_r, state_s;

  logic [CNT_W-1:0]  bit_cnt_r;
  logic [WORD_W-1:0] shift_r;
  logic [RUN_W-1:0]  run_r;
  logic              last_bit_r;
  logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;

  logic              accept_s;
  logic [RUN_W-1:0]  run_inc_s;
  logic              trip_s;
  logic [WORD_W-1:0] word_s;
  logic              complete_s;
  logic              push_req_s;
  logic              pop_s;
  logic              full_s;
  logic              push_s;
  logic              drop_s;
  logic [FCNT_W-1:0] count_next_s;
  logic [PTR_W-1:0]  rd_next_ptr_s;

  // Datapath decode: bit acceptance, run-length update, word completion, FIFO handshake.
  always_comb begin
    accept_s      = (state_r == ST_PACK) && in_valid && !clear_err;
    run_inc_s     = run_r;
    word_s        = shift_r;
    rd_next_ptr_s = rd_ptr_r + PTR_W'(1);

    if ((run_r == '0) || (in_bit != last_bit_r)) begin
      run_inc_s = RUN_W'(1);
    end else if (run_r == RUN_MAX) begin
      run_inc_s = RUN_MAX;
    end else begin
      run_inc_s = run_r + RUN_W'(1);
    end

    word_s[bit_cnt_r] = in_bit;

    trip_s     = accept_s && (run_inc_s == RUN_MAX);
    complete_s = accept_s && (bit_cnt_r == LAST_IDX);
    // A word completing on the tripping bit is contaminated and never stored.
    push_req_s = complete_s && !trip_s;

    pop_s  = word_valid && word_ready;
    full_s = (fifo_count == DEPTH_C);
    // A same-edge pop frees the slot a full FIFO needs for the new word.
    push_s = push_req_s && (!full_s || pop_s);
    drop_s = push_req_s && full_s && !pop_s;

    count_next_s = fifo_count + {{(FCNT_W-1){1'b0}}, push_s}
                              - {{(FCNT_W-1){1'b0}}, pop_s};
  end

  // Packing mode next-state: halt on health failure, resume on clear_err.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_PACK: begin
        if (clear_err) begin
          state_s = ST_PACK;
        end else if (trip_s) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_PACK;
        end
      end
      ST_HALT: begin
        if (clear_err) begin
          state_s = ST_PACK;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: state_s = ST_PACK;
    endcase
  end

  // Packing mode register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_PACK;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift register, bit counter and repetition-run tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      run_r      <= '0;
      last_bit_r <= 1'b0;
    end else if (clear_err) begin
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      run_r      <= '0;
      last_bit_r <= 1'b0;
    end else if (accept_s) begin
      run_r      <= run_inc_s;
      last_bit_r <= in_bit;
      if (trip_s || complete_s) begin
        bit_cnt_r <= '0;
        shift_r   <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        shift_r   <= word_s;
      end
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      rep_fail <= 1'b0;
    end else if (clear_err) begin
      overflow <= 1'b0;
      rep_fail <= 1'b0;
    end else begin
      if (drop_s) overflow <= 1'b1;
      if (trip_s) rep_fail <= 1'b1;
    end
  end

  // FIFO storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // FIFO pointers, occupancy and the registered first-word-fall-through head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_count <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_next_ptr_s;
      fifo_count <= count_next_s;
      word_valid <= (count_next_s != '0);
      if (pop_s) begin
        // Next head is either an already-stored entry or the word arriving now.
        if (fifo_count > FCNT_W'(1)) begin
          word_data <= mem_r[rd_next_ptr_s];
        end else if (push_s) begin
          word_data <= word_s;
        end
      end else if (push_s && (fifo_count == '0)) begin
        word_data <= word_s;
      end
    end
  end

endmodule

// File: tb/tb_trng_word_packer.sv
module tb_trng_word_packer;

  localparam int DEPTH = 4;
  localparam int LIMIT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       clear_err;
  logic       word_valid;
  logic       word_ready;
  logic [7:0] word_data;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       rep_fail;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] m_shift;
  int         m_cnt;
  int         m_run;
  logic       m_last;
  logic       m_halt;
  logic       m_ovf;
  logic       m_rep;
  int         pops_seen;
  int         words_made;
  logic [7:0] last_pop;

  trng_word_packer #(.WORD_W(8), .FIFO_DEPTH(DEPTH), .REP_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear_err(clear_err), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .fifo_count(fifo_count), .overflow(overflow),
    .rep_fail(rep_fail)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    m_shift = 8'h00; m_cnt = 0; m_run = 0; m_last = 1'b0;
    m_halt = 1'b0; m_ovf = 1'b0; m_rep = 1'b0;
  endtask

  // One clock cycle: compare pre-edge outputs against the model, then advance both.
  task automatic step();
    logic       pop;
    logic       full;
    logic       trip;
    logic [7:0] w;
    logic [7:0] popped;
    logic [2:0] exp_cnt;
    exp_cnt = 3'(exp_q.size());
    checks++;
    if (word_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL sb_word_valid: got %b expected %b", word_valid, exp_q.size() != 0);
    end
    checks++;
    if (fifo_count !== exp_cnt) begin
      errors++; $display("FAIL sb_fifo_count: got %0d expected %0d", fifo_count, exp_cnt);
    end
    checks++;
    if ({overflow, rep_fail} !== {m_ovf, m_rep}) begin
      errors++; $display("FAIL sb_flags: got ovf=%b rep=%b expected ovf=%b rep=%b", overflow, rep_fail, m_ovf, m_rep);
    end
    pop  = (exp_q.size() != 0) && word_ready;
    full = (exp_q.size() == DEPTH);
    if (pop) begin
      popped = exp_q.pop_front();
      checks++;
      if (word_data !== popped) begin
        errors++; $display("FAIL sb_word_data: got %h expected %h", word_data, popped);
      end
      last_pop = word_data;
      pops_seen++;
    end
    if (clear_err) begin
      m_ovf = 1'b0; m_rep = 1'b0; m_run = 0; m_cnt = 0; m_shift = 8'h00; m_halt = 1'b0;
    end else if (in_valid && !m_halt) begin
      if (m_run == 0 || in_bit != m_last) m_run = 1;
      else if (m_run < LIMIT) m_run++;
      m_last = in_bit;
      trip = (m_run == LIMIT);
      w = m_shift;
      w[m_cnt] = in_bit;
      if (trip) begin
        m_rep = 1'b1; m_halt = 1'b1; m_cnt = 0; m_shift = 8'h00;
      end else if (m_cnt == 7) begin
        m_cnt = 0; m_shift = 8'h00; words_made++;
        if (!full || pop) exp_q.push_back(w);
        else m_ovf = 1'b1;
      end else begin
        m_shift = w; m_cnt++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1; in_bit = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic pulse_clear(input logic with_bit);
    clear_err = 1'b1; in_valid = with_bit; in_bit = 1'b1;
    step();
    clear_err = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_err = 1'b0; word_ready = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({word_valid, word_data, fifo_count, overflow, rep_fail} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h c=%0d o=%b r=%b expected all zero",
                         word_valid, word_data, fifo_count, overflow, rep_fail);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_word();
    logic [7:0] pat;
    pat = 8'h4D;
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(pat[i]);
    checks++;
    if (word_valid !== 1'b1 || word_data !== 8'h4D) begin
      errors++; $display("FAIL single_word_out: got v=%b d=%h expected v=1 d=4d", word_valid, word_data);
    end
    step();
    checks++;
    if (fifo_count !== 3'd0 || word_data !== 8'h4D) begin
      errors++; $display("FAIL single_word_drain: got c=%0d d=%h expected c=0 d=4d", fifo_count, word_data);
    end
  endtask

  task automatic test_overflow();
    int p0;
    word_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(8'h55);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_set: got c=%0d o=%b expected c=4 o=1", fifo_count, overflow);
    end
    p0 = pops_seen;
    word_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (pops_seen - p0 != 4 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL overflow_drain: got pops=%0d c=%0d expected pops=4 c=0", pops_seen - p0, fifo_count);
    end
    pulse_clear(1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] w5;
    w5 = 8'hC3;
    word_ready = 1'b0;
    send_word(8'h96); send_word(8'h69); send_word(8'hA5); send_word(8'h3C);
    for (int i = 0; i < 7; i++) send_bit(w5[i]);
    word_ready = 1'b1;
    send_bit(w5[7]);
    word_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_push_pop: got c=%0d o=%b expected c=4 o=0", fifo_count, overflow);
    end
    word_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (last_pop !== 8'hC3) begin
      errors++; $display("FAIL full_push_pop_order: got last %h expected c3", last_pop);
    end
  endtask

  task automatic test_rep_fail();
    pulse_clear(1'b0);
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    checks++;
    if (rep_fail !== 1'b1 || fifo_count !== 3'd1 || word_data !== 8'hFF) begin
      errors++; $display("FAIL rep_trip: got r=%b c=%0d d=%h expected r=1 c=1 d=ff", rep_fail, fifo_count, word_data);
    end
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++; $display("FAIL rep_halt_ignore: got c=%0d expected 1", fifo_count);
    end
    pulse_clear(1'b1);
    checks++;
    if (rep_fail !== 1'b0) begin
      errors++; $display("FAIL rep_clear: got %b expected 0", rep_fail);
    end
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++; $display("FAIL rep_resume_count: got c=%0d expected 2", fifo_count);
    end
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (last_pop !== 8'hAA) begin
      errors++; $display("FAIL rep_resume_word: got %h expected aa", last_pop);
    end
  endtask

  task automatic test_reset_mid_word();
    word_ready = 1'b0;
    send_word(8'h55);
    for (int i = 0; i < 5; i++) send_bit(~i[0]);
    reset = 1'b1;
    model_reset();
    #2;
    checks++;
    if ({word_valid, word_data, fifo_count, overflow, rep_fail} !== 13'd0) begin
      errors++; $display("FAIL reset_mid_word: got v=%b d=%h c=%0d expected all zero", word_valid, word_data, fifo_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(~i[0]);
    checks++;
    if (word_valid !== 1'b1 || word_data !== 8'h55 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL reset_fresh_word: got v=%b d=%h c=%0d expected v=1 d=55 c=1", word_valid, word_data, fifo_count);
    end
    word_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int   p0;
    int   w0;
    logic b;
    p0 = pops_seen;
    w0 = words_made;
    for (int cyc = 0; cyc < 240; cyc++) begin
      word_ready = ($urandom_range(0, 3) == 0) || (cyc % 24 == 23);
      if (cyc % 3 == 0) begin
        b = 1'($urandom_range(0, 1));
        if (m_run >= 14 && b == m_last) b = ~b;
        in_valid = 1'b1; in_bit = b;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (overflow !== 1'b0 || rep_fail !== 1'b0 || (pops_seen - p0) != 10 || (words_made - w0) != 10) begin
      errors++; $display("FAIL gapped_stream: got o=%b r=%b pops=%0d words=%0d expected o=0 r=0 pops=10 words=10",
                         overflow, rep_fail, pops_seen - p0, words_made - w0);
    end
  endtask

  initial begin
    pops_seen = 0;
    words_made = 0;
    last_pop = 8'h00;
    test_reset();
    test_single_word();
    test_overflow();
    test_full_push_pop();
    test_rep_fail();
    test_reset_mid_word();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
